// File: rtl/exe_alu_arbiter.sv
// exe_alu_arbiter
//   Shares one execute-stage ALU datapath between NUM_REQ requesters.
//   A round-robin arbiter picks one packed ALU command per cycle and loads
//   it into an issue register that drives the EXE stage. The following
//   cycle the (combinational) EXE outputs are captured with the winner's ID
//   into a response register that has valid/ready backpressure.
//
//   Ports
//     clk, rst_n           clock (rising edge), asynchronous active-low reset
//     flush                synchronous pipeline flush, discards in-flight ops
//     req_valid/req_ready  per-requester command handshake
//     req_a/b/immd/ctrl    packed per-requester operands and control
//                          ctrl: [30] RegDst [29:25] rd [24:20] rt
//                                [19:14] opcode [13:8] funct [7:3] shamt
//                                [2:1] ALUOp [0] ALUSrc
//     exe_*  (out)         issue register fields to the EXE stage
//     exe_*  (in)          write address, result and flags from the EXE stage
//     rsp_*                registered response with requester ID
//     busy                 issue or response register holds a valid op
//
//   Optional build macro EXE_OVF_TRAP_EN adds ovf_clr (in), ovf_trap and
//   ovf_id (out): a sticky trap on the first overflowing response that
//   stops new grants until cleared.
module exe_alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CTRL_W  = 31
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*32-1:0]     req_a,
    input  logic [NUM_REQ*32-1:0]     req_b,
    input  logic [NUM_REQ*32-1:0]     req_immd,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl,
    output logic [31:0]               exe_a,
    output logic [31:0]               exe_b,
    output logic [31:0]               exe_immd,
    output logic [5:0]                exe_opcode,
    output logic [5:0]                exe_funct,
    output logic [4:0]                exe_shamt,
    output logic [1:0]                exe_aluop,
    output logic                      exe_alusrc,
    output logic                      exe_regdst,
    output logic [4:0]                exe_rd_addr,
    output logic [4:0]                exe_rt_addr,
    input  logic [4:0]                exe_write_addr,
    input  logic [31:0]               exe_result,
    input  logic                      exe_overflow,
    input  logic                      exe_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [4:0]                rsp_write_addr,
    output logic [31:0]               rsp_result,
    output logic                      rsp_overflow,
    output logic                      rsp_zero,
    output logic                      busy
`ifdef EXE_OVF_TRAP_EN
    ,
    input  logic                      ovf_clr,
    output logic                      ovf_trap,
    output logic [ID_W-1:0]           ovf_id
`endif
);

    // ---------------------------------------------------------------
    // Per-requester field slices
    // ---------------------------------------------------------------
    logic [31:0]       a_arr    [NUM_REQ];
    logic [31:0]       b_arr    [NUM_REQ];
    logic [31:0]       immd_arr [NUM_REQ];
    logic [CTRL_W-1:0] ctrl_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign a_arr[gi]    = req_a[32*gi +: 32];
        assign b_arr[gi]    = req_b[32*gi +: 32];
        assign immd_arr[gi] = req_immd[32*gi +: 32];
        assign ctrl_arr[gi] = req_ctrl[CTRL_W*gi +: CTRL_W];
    end

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    logic              iss_valid_reg;
    logic [ID_W-1:0]   iss_id_reg;
    logic [31:0]       iss_a_reg;
    logic [31:0]       iss_b_reg;
    logic [31:0]       iss_immd_reg;
    logic [CTRL_W-1:0] iss_ctrl_reg;

    logic              rsp_valid_reg;
    logic [ID_W-1:0]   rsp_id_reg;
    logic [4:0]        rsp_write_addr_reg;
    logic [31:0]       rsp_result_reg;
    logic              rsp_overflow_reg;
    logic              rsp_zero_reg;

    logic [ID_W-1:0]   rr_ptr_reg;
    logic [ID_W-1:0]   rr_ptr_next;

    logic              adv;
    logic              trap_block;

    // Both pipeline registers move together; a stalled response freezes
    // the issue register too, so the EXE inputs stay stable.
    assign adv = ~rsp_valid_reg | rsp_ready;

    // ---------------------------------------------------------------
    // Round-robin arbiter
    //   Requests at or above rr_ptr take precedence; if there are none the
    //   search wraps to the lowest requester. The lowest set bit of the
    //   chosen vector is isolated with v & -v.
    // ---------------------------------------------------------------
    logic [NUM_REQ-1:0] lo_mask;
    logic [NUM_REQ-1:0] upper_valid;
    logic [NUM_REQ-1:0] pick_vec;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] grant_vec;
    logic               grant_en;
    logic               grant_any;

    assign lo_mask     = (NUM_REQ'(1) << rr_ptr_reg) - NUM_REQ'(1);
    assign upper_valid = req_valid & ~lo_mask;
    assign pick_vec    = (|upper_valid) ? upper_valid : req_valid;
    assign win_onehot  = pick_vec & (~pick_vec + NUM_REQ'(1));

    // rst_n gates the grant so req_ready is quiet while reset is held.
    assign grant_en  = rst_n & adv & ~flush & ~trap_block;
    assign grant_vec = grant_en ? win_onehot : '0;
    assign grant_any = |grant_vec;
    assign req_ready = grant_vec;

    logic [ID_W-1:0]   win_id;
    logic [31:0]       win_a;
    logic [31:0]       win_b;
    logic [31:0]       win_immd;
    logic [CTRL_W-1:0] win_ctrl;

    // One-hot select; at most one bit of win_onehot is set.
    always_comb begin
        win_id   = '0;
        win_a    = '0;
        win_b    = '0;
        win_immd = '0;
        win_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                win_id   = ID_W'(i);
                win_a    = a_arr[i];
                win_b    = b_arr[i];
                win_immd = immd_arr[i];
                win_ctrl = ctrl_arr[i];
            end
        end
    end

    assign rr_ptr_next = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);

    // ---------------------------------------------------------------
    // Issue and response registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_reg      <= 1'b0;
            iss_id_reg         <= '0;
            iss_a_reg          <= '0;
            iss_b_reg          <= '0;
            iss_immd_reg       <= '0;
            iss_ctrl_reg       <= '0;
            rsp_valid_reg      <= 1'b0;
            rsp_id_reg         <= '0;
            rsp_write_addr_reg <= '0;
            rsp_result_reg     <= '0;
            rsp_overflow_reg   <= 1'b0;
            rsp_zero_reg       <= 1'b0;
            rr_ptr_reg         <= '0;
        end else if (flush) begin
            // Discard everything in flight; data registers and pointer hold.
            iss_valid_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
        end else if (adv) begin
            rsp_valid_reg <= iss_valid_reg;
            if (iss_valid_reg) begin
                // EXE is combinational on the issue register, so its outputs
                // belong to the op currently in iss.
                rsp_id_reg         <= iss_id_reg;
                rsp_write_addr_reg <= exe_write_addr;
                rsp_result_reg     <= exe_result;
                rsp_overflow_reg   <= exe_overflow;
                rsp_zero_reg       <= exe_zero;
            end
            iss_valid_reg <= grant_any;
            if (grant_any) begin
                iss_id_reg   <= win_id;
                iss_a_reg    <= win_a;
                iss_b_reg    <= win_b;
                iss_immd_reg <= win_immd;
                iss_ctrl_reg <= win_ctrl;
                rr_ptr_reg   <= rr_ptr_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Overflow trap (optional)
    // ---------------------------------------------------------------
`ifdef EXE_OVF_TRAP_EN
    logic            ovf_trap_reg;
    logic [ID_W-1:0] ovf_id_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_trap_reg <= 1'b0;
            ovf_id_reg   <= '0;
        end else if (ovf_clr) begin
            ovf_trap_reg <= 1'b0;
            ovf_id_reg   <= '0;
        end else if (!ovf_trap_reg && rsp_valid_reg && rsp_ready && rsp_overflow_reg) begin
            // Only the first offender is recorded until software clears it.
            ovf_trap_reg <= 1'b1;
            ovf_id_reg   <= rsp_id_reg;
        end
    end

    assign trap_block = ovf_trap_reg;
    assign ovf_trap   = ovf_trap_reg;
    assign ovf_id     = ovf_id_reg;
`else
    assign trap_block = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign exe_a       = iss_a_reg;
    assign exe_b       = iss_b_reg;
    assign exe_immd    = iss_immd_reg;
    assign exe_regdst  = iss_ctrl_reg[30];
    assign exe_rd_addr = iss_ctrl_reg[29:25];
    assign exe_rt_addr = iss_ctrl_reg[24:20];
    assign exe_opcode  = iss_ctrl_reg[19:14];
    assign exe_funct   = iss_ctrl_reg[13:8];
    assign exe_shamt   = iss_ctrl_reg[7:3];
    assign exe_aluop   = iss_ctrl_reg[2:1];
    assign exe_alusrc  = iss_ctrl_reg[0];

    assign rsp_valid      = rsp_valid_reg;
    assign rsp_id         = rsp_id_reg;
    assign rsp_write_addr = rsp_write_addr_reg;
    assign rsp_result     = rsp_result_reg;
    assign rsp_overflow   = rsp_overflow_reg;
    assign rsp_zero       = rsp_zero_reg;
    assign busy           = iss_valid_reg | rsp_valid_reg;

endmodule

// File: tb/tb_exe_alu_arbiter.sv
// Testbench for exe_alu_arbiter (default build).
// A small combinational EXE stage stub closes the loop; a transaction-level
// model of the arbiter/pipeline is checked against the DUT every cycle, and
// directed sequences pin grant order, latency, backpressure, flush and reset.
module tb_exe_alu_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a, req_b, req_immd;
    logic [N*CW-1:0] req_ctrl;
    logic [31:0]     exe_a, exe_b, exe_immd;
    logic [5:0]      exe_opcode, exe_funct;
    logic [4:0]      exe_shamt;
    logic [1:0]      exe_aluop;
    logic            exe_alusrc, exe_regdst;
    logic [4:0]      exe_rd_addr, exe_rt_addr;
    logic [4:0]      exe_write_addr;
    logic [31:0]     exe_result;
    logic            exe_overflow, exe_zero;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [IW-1:0]   rsp_id;
    logic [4:0]      rsp_write_addr;
    logic [31:0]     rsp_result;
    logic            rsp_overflow, rsp_zero;
    logic            busy;

    logic [31:0]     a_arr [N];
    logic [31:0]     b_arr [N];
    logic [31:0]     i_arr [N];
    logic [CW-1:0]   c_arr [N];

    always_comb begin
        req_a    = '0;
        req_b    = '0;
        req_immd = '0;
        req_ctrl = '0;
        for (int i = 0; i < N; i++) begin
            req_a[i*32 +: 32]    = a_arr[i];
            req_b[i*32 +: 32]    = b_arr[i];
            req_immd[i*32 +: 32] = i_arr[i];
            req_ctrl[i*CW +: CW] = c_arr[i];
        end
    end

    exe_alu_arbiter #(.NUM_REQ(N), .ID_W(IW), .CTRL_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_immd(req_immd), .req_ctrl(req_ctrl),
        .exe_a(exe_a), .exe_b(exe_b), .exe_immd(exe_immd),
        .exe_opcode(exe_opcode), .exe_funct(exe_funct), .exe_shamt(exe_shamt),
        .exe_aluop(exe_aluop), .exe_alusrc(exe_alusrc), .exe_regdst(exe_regdst),
        .exe_rd_addr(exe_rd_addr), .exe_rt_addr(exe_rt_addr),
        .exe_write_addr(exe_write_addr), .exe_result(exe_result),
        .exe_overflow(exe_overflow), .exe_zero(exe_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_write_addr(rsp_write_addr), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .busy(busy)
    );

    // ---------------- EXE stage stub ----------------
    typedef struct packed {
        logic [4:0]  wa;
        logic [31:0] res;
        logic        ovf;
        logic        zero;
    } alu_t;

    function automatic alu_t alu_f(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] immd, input logic [5:0] funct,
                                   input logic alusrc, input logic regdst,
                                   input logic [4:0] rd, input logic [4:0] rt);
        alu_t r;
        logic [31:0] op2;
        op2 = alusrc ? immd : b;
        r.ovf = 1'b0;
        case (funct)
            6'h20: begin
                r.res = a + op2;
                r.ovf = (a[31] == op2[31]) && (r.res[31] != a[31]);
            end
            6'h22: begin
                r.res = a - op2;
                r.ovf = (a[31] != op2[31]) && (r.res[31] != a[31]);
            end
            6'h24:   r.res = a & op2;
            6'h25:   r.res = a | op2;
            default: r.res = a + op2;
        endcase
        r.zero = (r.res == 32'd0);
        r.wa   = regdst ? rd : rt;
        return r;
    endfunction

    alu_t stub;
    always_comb stub = alu_f(exe_a, exe_b, exe_immd, exe_funct, exe_alusrc,
                             exe_regdst, exe_rd_addr, exe_rt_addr);
    assign exe_write_addr = stub.wa;
    assign exe_result     = stub.res;
    assign exe_overflow   = stub.ovf;
    assign exe_zero       = stub.zero;

    function automatic logic [CW-1:0] mk_ctrl(input logic regdst, input logic [4:0] rd,
                                              input logic [4:0] rt, input logic [5:0] opcode,
                                              input logic [5:0] funct, input logic [4:0] shamt,
                                              input logic [1:0] aluop, input logic alusrc);
        return {regdst, rd, rt, opcode, funct, shamt, aluop, alusrc};
    endfunction

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: one op slot in issue, one in response, plus the pointer.
    logic          m_iss_v, m_rsp_v;
    int            m_iss_id, m_rsp_id, m_ptr;
    logic [31:0]   m_a, m_b, m_i;
    logic [CW-1:0] m_c;
    alu_t          m_rsp;
    logic          m_adv;
    int            m_w;
    logic [N-1:0]  m_rdy;

    int grant_log[$];
    int rsp_log[$];

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_iss_v = 1'b0; m_rsp_v = 1'b0;
                m_iss_id = 0; m_rsp_id = 0; m_ptr = 0;
                m_a = '0; m_b = '0; m_i = '0; m_c = '0;
                m_rsp = '0;
            end else begin
                m_adv = !m_rsp_v || rsp_ready;
                m_w = -1;
                if (m_adv && !flush) begin
                    for (int k = 0; k < N; k++) begin
                        if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
                    end
                end
                m_rdy = (m_w >= 0) ? N'(1 << m_w) : '0;

                chk("req_ready", 32'(req_ready), 32'(m_rdy));
                chk("exe_a", exe_a, m_a);
                chk("exe_b", exe_b, m_b);
                chk("exe_immd", exe_immd, m_i);
                chk("exe_ctrl", {exe_regdst, exe_rd_addr, exe_rt_addr, exe_opcode,
                                 exe_funct, exe_shamt, exe_aluop, exe_alusrc}, 32'(m_c));
                chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_v));
                chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
                chk("rsp_write_addr", 32'(rsp_write_addr), 32'(m_rsp.wa));
                chk("rsp_result", rsp_result, m_rsp.res);
                chk("rsp_flags", {30'd0, rsp_overflow, rsp_zero}, {30'd0, m_rsp.ovf, m_rsp.zero});
                chk("busy", 32'(busy), 32'(m_iss_v | m_rsp_v));

                for (int i = 0; i < N; i++)
                    if (req_valid[i] && req_ready[i]) grant_log.push_back(i);
                if (rsp_valid && rsp_ready) rsp_log.push_back(int'(rsp_id));

                @(posedge clk);
                if (rst_n) begin
                    if (flush) begin
                        m_iss_v = 1'b0;
                        m_rsp_v = 1'b0;
                    end else if (m_adv) begin
                        m_rsp_v = m_iss_v;
                        if (m_iss_v) begin
                            m_rsp_id = m_iss_id;
                            m_rsp = alu_f(m_a, m_b, m_i, m_c[13:8], m_c[0], m_c[30],
                                          m_c[29:25], m_c[24:20]);
                        end
                        m_iss_v = (m_w >= 0);
                        if (m_w >= 0) begin
                            m_iss_id = m_w;
                            m_a = a_arr[m_w]; m_b = b_arr[m_w];
                            m_i = i_arr[m_w]; m_c = c_arr[m_w];
                            m_ptr = (m_w + 1) % N;
                        end
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [31:0] snap_a, snap_res;
    int          exp_rr[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int          exp_gap[3] = '{1, 2, 0};

    initial begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = 32'h100 * (i + 1);
            b_arr[i] = 32'h11 * (i + 1);
            i_arr[i] = 32'h3 + i;
            c_arr[i] = mk_ctrl(1'b1, 5'(i + 1), 5'(i + 8), 6'd0, 6'h20, 5'd0, 2'b10, 1'b0);
        end

        // Reset then idle
        rst_n = 1'b0;
        tick();
        tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_exe_a", exe_a, 32'd0);
        chk("reset_rsp_result", rsp_result, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_req_ready", 32'(req_ready), 32'd0);

        // Single op from requester 2: 5 + 7
        a_arr[2] = 32'd5; b_arr[2] = 32'd7;
        c_arr[2] = mk_ctrl(1'b1, 5'd3, 5'd4, 6'd0, 6'h20, 5'd0, 2'b10, 1'b0);
        req_valid = 4'b0100;
        settle();
        chk("single_ready", 32'(req_ready), 32'h4);
        tick();
        req_valid = '0;
        settle();
        chk("single_lat1", 32'(rsp_valid), 32'd0);
        tick();
        chk("single_lat2_valid", 32'(rsp_valid), 32'd1);
        chk("single_id", 32'(rsp_id), 32'd2);
        chk("single_result", rsp_result, 32'd12);
        chk("single_wa", 32'(rsp_write_addr), 32'd3);
        tick();

        // Overflow op from requester 3 (pointer is 3 now)
        a_arr[3] = 32'h7FFF_FFFF; b_arr[3] = 32'd1;
        c_arr[3] = mk_ctrl(1'b1, 5'd7, 5'd6, 6'd0, 6'h20, 5'd0, 2'b10, 1'b0);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        tick();
        chk("ovf_valid", 32'(rsp_valid), 32'd1);
        chk("ovf_id", 32'(rsp_id), 32'd3);
        chk("ovf_result", rsp_result, 32'h8000_0000);
        chk("ovf_flag", 32'(rsp_overflow), 32'd1);
        tick();

        // SUB to zero from requester 0, RegDst=0 selects rt
        a_arr[0] = 32'd9; b_arr[0] = 32'd9;
        c_arr[0] = mk_ctrl(1'b0, 5'd1, 5'd9, 6'd0, 6'h22, 5'd0, 2'b10, 1'b0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        chk("zero_flag", 32'(rsp_zero), 32'd1);
        chk("zero_wa", 32'(rsp_write_addr), 32'd9);
        chk("zero_ovf", 32'(rsp_overflow), 32'd0);
        tick();

        // Round robin from a fresh pointer
        do_reset();
        grant_log.delete();
        req_valid = 4'b1111;
        repeat (8) tick();
        req_valid = '0;
        chk("rr_count", 32'(grant_log.size()), 32'd8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(exp_rr[i]));
        repeat (3) tick();

        // Round robin with a gap
        grant_log.delete();
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0101;
        tick();
        tick();
        req_valid = '0;
        chk("gap_count", 32'(grant_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < grant_log.size(); i++)
            chk($sformatf("gap_grant%0d", i), 32'(grant_log[i]), 32'(exp_gap[i]));
        repeat (3) tick();

        // Backpressure
        grant_log.delete();
        rsp_log.delete();
        req_valid = 4'b1111;
        repeat (3) tick();
        rsp_ready = 1'b0;
        settle();
        snap_a = exe_a;
        snap_res = rsp_result;
        chk("bp_ready0", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_exe_hold", exe_a, snap_a);
            chk("bp_rsp_hold", rsp_result, snap_res);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
        chk("bp_rsp_count", 32'(rsp_log.size()), 32'(grant_log.size()));
        for (int i = 0; i < rsp_log.size() && i < grant_log.size(); i++)
            chk($sformatf("bp_order%0d", i), 32'(rsp_log[i]), 32'(grant_log[i]));

        // Flush with both stages full; pointer must stay at 2
        do_reset();
        req_valid = 4'b1111;
        tick();
        tick();
        chk("fl_full", 32'(busy & rsp_valid), 32'd1);
        flush = 1'b1;
        settle();
        chk("fl_ready", 32'(req_ready), 32'd0);
        tick();
        flush = 1'b0;
        settle();
        chk("fl_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_ptr", 32'(req_ready), 32'h4);
        req_valid = '0;
        tick();

        // Reset asserted mid-operation
        req_valid = 4'b1111;
        tick();
        tick();
        rst_n = 1'b0;
        settle();
        chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_exe_a", exe_a, 32'd0);
        chk("mr_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        tick();
        rst_n = 1'b1;
        tick();

        // Mixed traffic, model-checked every cycle
        c_arr[1] = mk_ctrl(1'b0, 5'd2, 5'd12, 6'h0d, 6'h25, 5'd4, 2'b11, 1'b1);
        c_arr[2] = mk_ctrl(1'b1, 5'd14, 5'd15, 6'd0, 6'h24, 5'd2, 2'b10, 1'b0);
        for (int i = 0; i < 48; i++) begin
            a_arr[1] = 32'(i * 3);
            a_arr[2] = 32'hF0F0_0000 | 32'(i);
            b_arr[2] = 32'hFF00_FF0F;
            a_arr[0] = 32'(i % 5);
            b_arr[0] = 32'd2;
            req_valid = N'((i * 5 + 3) % 16);
            rsp_ready = (i % 4) != 1;
            flush = (i == 20) || (i == 33);
            tick();
        end
        flush = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/exe_alu_arbiter.md
Name: exe_alu_arbiter

Overview:
- Shares the single execute-stage ALU datapath (EXE stage instance) between NUM_REQ requesters, such as vector lanes and the scalar pipe.
- Round-robin arbitrates packed ALU commands and registers the winner into an issue register that drives the EXE stage.
- Captures the EXE result with the requester ID into a response register under valid/ready backpressure.
- Two-stage pipeline: issue, then response. Throughput is one op per cycle.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; NUM_REQ <= 2**ID_W.
- CTRL_W, 31, packed command-control width (fixed layout, below).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept.
- req_a  in  NUM_REQ*32  rs operand, requester i at [32i+31:32i].
- req_b  in  NUM_REQ*32  rt operand.
- req_immd  in  NUM_REQ*32  sign-extended immediate.
- req_ctrl  in  NUM_REQ*CTRL_W  packed control, layout per requester: [30] RegDst, [29:25] rd, [24:20] rt, [19:14] opcode, [13:8] funct, [7:3] shamt, [2:1] ALUOp, [0] ALUSrc.
- exe_a, exe_b, exe_immd  out  32 each  operands to the EXE stage.
- exe_opcode  out  6  opcode to the EXE stage.
- exe_funct  out  6  funct to the EXE stage.
- exe_shamt  out  5  shift amount to the EXE stage.
- exe_aluop  out  2  ALUOp to the EXE stage.
- exe_alusrc  out  1  ALUSrc to the EXE stage.
- exe_regdst  out  1  RegDst to the EXE stage.
- exe_rd_addr, exe_rt_addr  out  5 each  destination candidates to the EXE stage.
- exe_write_addr  in  5  from the EXE stage.
- exe_result  in  32  from the EXE stage.
- exe_overflow  in  1  from the EXE stage.
- exe_zero  in  1  from the EXE stage.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_write_addr  out  5  registered destination address.
- rsp_result  out  32  registered ALU result.
- rsp_overflow, rsp_zero  out  1 each  registered ALU flags.
- busy  out  1  iss_valid | rsp_valid.

Behaviour:
- Reset (async, rst_n=0): iss_valid=0, rsp_valid=0, rr_ptr=0.
  - All exe_* and rsp_* data outputs = 0; req_ready=0; busy=0.
- Advance: adv = !rsp_valid | rsp_ready.
  - When adv=0, the issue and response registers both hold.
  - The exe_* outputs stay stable while held.
- Arbitration (combinational, only when adv=1 and flush=0):
  - Scan req_valid starting at rr_ptr, ascending, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready is one-hot for the winner and 0 otherwise.
  - A handshake is req_valid[i] & req_ready[i].
- rr_ptr update:
  - On a grant, rr_ptr <= (winner+1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
  - Flush does not change rr_ptr.
- Issue register (when adv=1):
  - Loads the winner's fields plus its ID, and sets iss_valid=1.
  - With no winner, iss_valid <= 0 and the data registers keep their old values.
  - exe_* outputs are driven directly from the issue register.
- Response register (when adv=1):
  - rsp_valid <= iss_valid.
  - If iss_valid=1, it captures exe_write_addr, exe_result, exe_overflow, exe_zero and the issue ID. The EXE stage is combinational, so its outputs are sampled in the cycle after issue.
- Latency: request handshake at cycle N, rsp_valid at cycle N+2. Back-to-back ops complete one per cycle while rsp_ready=1.
- Backpressure: rsp_valid=1 & rsp_ready=0 forces req_ready=0 for all requesters. No ops are lost or duplicated.
- Flush=1 at a clock edge:
  - iss_valid <= 0 and rsp_valid <= 0. In-flight ops are discarded with no response.
  - req_ready=0 in that cycle.
  - Flush has priority over both grant and advance.
- Simultaneous rsp handshake and new grant in the same cycle is legal; the pipeline shifts.
- Reset asserted mid-operation: all state clears immediately, and ops in flight are dropped.

Optional Feature:
- Macro: EXE_OVF_TRAP_EN.
- Defined:
  - On a response handshake with rsp_overflow=1, set sticky outputs ovf_trap (1 bit) and ovf_id (ID_W, first offender only).
  - While ovf_trap=1, req_ready=0 for all requesters; in-flight ops still drain.
  - Additional input ovf_clr (1 bit): synchronous, clears ovf_trap and ovf_id. Reset also clears them.
- Not defined:
  - ovf_trap, ovf_id and ovf_clr are absent.
  - rsp_overflow is informational only and arbitration is unaffected.

Test Plan:
- Reset then idle: all req_valid=0 → req_ready=0, rsp_valid=0, busy=0, rr_ptr=0.
- Single op: requester 2 sends ADD, a=5, b=7 → rsp_valid exactly 2 cycles after the handshake, rsp_id=2, rsp_result=12.
- Round-robin: req_valid=4'b1111 held for 8 cycles with rsp_ready=1 → grant order 0,1,2,3,0,1,2,3.
- Round-robin with a gap: requester 1 alone, then 4'b0101 → next grant is 2, then 0.
- Backpressure: rsp_ready=0 for 3 cycles with all requesters valid → rsp_* and exe_* stable, req_ready=0.
  - After release, responses arrive in grant order with none lost.
- Flush: assert flush while iss_valid=1 and rsp_valid=1 → next cycle rsp_valid=0, iss_valid=0, and rr_ptr is unchanged.
- Overflow trap (EXE_OVF_TRAP_EN defined): requester 3 sends ADD 0x7FFFFFFF+1 → ovf_trap=1, ovf_id=3, req_ready=0 until ovf_clr.
